// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared VGA timing defaults (640x480 @ 800x525), derived data-enable
//   window bounds, frame-buffer size and capture FSM state encoding.
//   Used by vga_capture and its sub-module via import vga_timing_pkg::*.
package vga_timing_pkg;

    // Default timing (pixel clocks horizontally, lines vertically)
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_TOTAL_DEF  = 525;

    // Derived data-enable window (start inclusive, end exclusive)
    localparam int HDE_START = H_SYNC_DEF + H_BACK_DEF;                 // 144
    localparam int HDE_END   = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF;  // 784
    localparam int VDE_START = V_SYNC_DEF + V_BACK_DEF;                 // 35
    localparam int VDE_END   = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF;  // 515
    localparam int FB_WORDS  = H_ACTIVE_DEF * V_ACTIVE_DEF;             // 307200

    // Saturation value of the 10-bit position counters
    localparam int CNT_MAX = 1023;

    // Capture FSM encoding
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge
//   Registers one active-low sync input (stage S1) and flags a falling edge
//   by comparing the S1 value with the previous S1 value.
//   Ports:
//     vga_clk  pixel clock, rising edge
//     rst      asynchronous, active-high reset (S1 and history reset to 1)
//     sync_in  raw sync pin
//     fall     high for one cycle while S1 shows the first low sample
module vga_sync_edge (
    input  logic vga_clk,
    input  logic rst,
    input  logic sync_in,
    output logic fall
);
    import vga_timing_pkg::*;

    logic sync_s1;
    logic sync_prev;

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            sync_s1   <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_s1   <= sync_in;
            sync_prev <= sync_s1;
        end
    end

    assign fall = sync_prev & ~sync_s1;

endmodule

// File: rtl/vga_capture.sv
// vga_capture
//   Locks onto an incoming VGA timing stream, verifies line and frame
//   lengths, and writes every active pixel of enabled frames into a
//   row-major frame buffer (address y*H_ACTIVE+x, data {r,g,b}).
//   Ports:
//     vga_clk, rst          pixel clock / async active-high reset
//     vga_hs, vga_vs        active-low syncs
//     vga_r/g/b             pixel colour
//     cap_en                capture enable, sampled at each frame start
//     wr_en/wr_addr/wr_data frame-buffer write port, no backpressure
//     locked                high while in LOCKED
//     frame_done            pulse the cycle after the final pixel write
//     err                   pulse on a timing violation
module vga_capture
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        cap_en,
    output logic        wr_en,
    output logic [18:0] wr_addr,
    output logic [23:0] wr_data,
    output logic        locked,
    output logic        frame_done,
    output logic        err
);

    localparam logic [9:0]  H_DE_S  = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  H_DE_E  = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_DE_S  = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_DE_E  = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0]  CNT_SAT = 10'(CNT_MAX);
    localparam logic [18:0] FB_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

    logic        hs_fall;
    logic        vs_fall;
    logic [23:0] rgb_s1;
    logic [9:0]  x_cnt;
    logic [9:0]  y_cnt;
    logic        vs_pending;
    logic        first_edge;
    logic [1:0]  state;
    logic        frame_cap;

    logic        y_reset;
    logic        line_err;
    logic        frame_err;
    logic        lost_err;
    logic        timing_err;
    logic        active;
    logic        do_write;

    vga_sync_edge u_hs_edge (
        .vga_clk (vga_clk),
        .rst     (rst),
        .sync_in (vga_hs),
        .fall    (hs_fall)
    );

    vga_sync_edge u_vs_edge (
        .vga_clk (vga_clk),
        .rst     (rst),
        .sync_in (vga_vs),
        .fall    (vs_fall)
    );

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) rgb_s1 <= '0;
        else     rgb_s1 <= {vga_r, vga_g, vga_b};
    end

    // A vs edge arms the next hs edge as frame start; a coincident vs/hs
    // edge restarts the frame on that very edge.
    assign y_reset = hs_fall && (vs_fall || vs_pending);

    // x_cnt is cleared on the edge that ends the detect cycle, so on a
    // correctly timed hs edge it still holds H_TOTAL-1 from the prior line.
    assign line_err   = hs_fall && !first_edge && (x_cnt != H_LAST);
    assign frame_err  = y_reset && (state != ST_SEARCH) && (y_cnt != V_LAST);
    assign lost_err   = !hs_fall && (x_cnt == CNT_SAT - 10'd1);
    assign timing_err = line_err || frame_err || lost_err;

    assign active   = (x_cnt >= H_DE_S) && (x_cnt < H_DE_E) &&
                      (y_cnt >= V_DE_S) && (y_cnt < V_DE_E);
    assign do_write = (state == ST_LOCKED) && frame_cap && active && !timing_err;

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            vs_pending <= 1'b0;
        end else begin
            if (hs_fall)               x_cnt <= '0;
            else if (x_cnt != CNT_SAT) x_cnt <= x_cnt + 10'd1;

            if (y_reset)                           y_cnt <= '0;
            else if (hs_fall && y_cnt != CNT_SAT)  y_cnt <= y_cnt + 10'd1;

            if (y_reset)      vs_pending <= 1'b0;
            else if (vs_fall) vs_pending <= 1'b1;
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SEARCH;
            first_edge <= 1'b1;
            frame_cap  <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= timing_err;
            if (y_reset) frame_cap <= cap_en;

            if (timing_err) begin
                state      <= ST_SEARCH;
                first_edge <= 1'b1;
            end else begin
                if (hs_fall) first_edge <= 1'b0;
                if (y_reset) begin
                    case (state)
                        ST_SEARCH: state <= ST_ARM;
                        ST_ARM:    state <= ST_LOCKED;
                        default:   state <= ST_LOCKED;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= do_write;
            frame_done <= wr_en && (wr_addr == FB_LAST);
            if (do_write) wr_data <= rgb_s1;

            // wr_addr names the pixel presented with wr_en and advances
            // after it; it holds at the last word until the next frame.
            if (y_reset)                           wr_addr <= '0;
            else if (wr_en && wr_addr != FB_LAST)  wr_addr <= wr_addr + 19'd1;
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture
//   Directed bench for vga_capture using a scaled timing (32x12 total,
//   16x6 active) so each frame is 384 clocks. Drives whole frames with a
//   (x,y,x^y) pixel pattern and checks lock sequencing, write stream,
//   frame_done, error handling and asynchronous reset.
module tb_vga_capture;

    localparam int TB_H_SYNC   = 4;
    localparam int TB_H_BACK   = 4;
    localparam int TB_H_ACTIVE = 16;
    localparam int TB_H_TOTAL  = 32;
    localparam int TB_V_SYNC   = 2;
    localparam int TB_V_BACK   = 2;
    localparam int TB_V_ACTIVE = 6;
    localparam int TB_V_TOTAL  = 12;
    localparam int HDE_S       = TB_H_SYNC + TB_H_BACK;
    localparam int HDE_E       = HDE_S + TB_H_ACTIVE;
    localparam int VDE_S       = TB_V_SYNC + TB_V_BACK;
    localparam int VDE_E       = VDE_S + TB_V_ACTIVE;
    localparam int FB          = TB_H_ACTIVE * TB_V_ACTIVE;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        vga_hs, vga_vs;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        cap_en;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic        locked, frame_done, err;

    vga_capture #(
        .H_SYNC   (TB_H_SYNC),
        .H_BACK   (TB_H_BACK),
        .H_ACTIVE (TB_H_ACTIVE),
        .H_TOTAL  (TB_H_TOTAL),
        .V_SYNC   (TB_V_SYNC),
        .V_BACK   (TB_V_BACK),
        .V_ACTIVE (TB_V_ACTIVE),
        .V_TOTAL  (TB_V_TOTAL)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .cap_en     (cap_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .locked     (locked),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int pix_cyc = 0;
    int first_wr_cyc = 0;
    int wr_cnt, done_cnt, err_cnt, exp_addr, post_err_wr;
    logic err_seen;
    logic prev_last_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int a);
        int x, y;
        x = a % TB_H_ACTIVE;
        y = a / TB_H_ACTIVE;
        return {8'(x), 8'(y), 8'(x ^ y)};
    endfunction

    task automatic clear_stats();
        wr_cnt      = 0;
        done_cnt    = 0;
        err_cnt     = 0;
        exp_addr    = 0;
        post_err_wr = 0;
        err_seen    = 1'b0;
    endtask

    always @(posedge vga_clk) cyc++;

    // Write-stream monitor: sampled 1 time unit after each rising edge.
    always @(posedge vga_clk) begin
        #1;
        if (!rst) begin
            if (frame_done) begin
                done_cnt++;
                check("fdone_after_last_wr", 32'(prev_last_wr), 32'd1);
            end
            if (err) begin
                err_cnt++;
                err_seen = 1'b1;
                check("err_blocks_wr", 32'(wr_en), 32'd0);
            end
            if (wr_en) begin
                if (err_seen) post_err_wr++;
                if (wr_cnt == 0) first_wr_cyc = cyc;
                wr_cnt++;
                check("wr_addr", 32'(wr_addr), 32'(exp_addr));
                check("wr_data", 32'(wr_data), 32'(exp_rgb(exp_addr)));
                exp_addr++;
            end
            prev_last_wr = wr_en && (exp_addr == FB);
        end
    end

    // Pin index i of a line is seen by the capture logic at x_cnt = i-1,
    // so active pixel x sits at pin index HDE_S+1+x.
    task automatic drive_line(input int line, input int len);
        int x, y;
        for (int i = 0; i < len; i++) begin
            @(negedge vga_clk);
            vga_hs = (i < TB_H_SYNC) ? 1'b0 : 1'b1;
            vga_vs = (line < TB_V_SYNC) ? 1'b0 : 1'b1;
            if (line >= VDE_S && line < VDE_E && i > HDE_S && i <= HDE_E) begin
                x = i - HDE_S - 1;
                y = line - VDE_S;
                {vga_r, vga_g, vga_b} = {8'(x), 8'(y), 8'(x ^ y)};
                if (x == 0 && y == 0) pix_cyc = cyc;
            end else begin
                {vga_r, vga_g, vga_b} = 24'hC0FFEE;
            end
        end
    endtask

    task automatic drive_frame(input int short_line);
        for (int line = 0; line < TB_V_TOTAL; line++)
            drive_line(line, (line == short_line) ? TB_H_TOTAL - 1 : TB_H_TOTAL);
    endtask

    task automatic frame_checks(input string tag, input int exp_wr, input int exp_done,
                                input int exp_err, input logic exp_lock);
        check({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
        check({tag, "_done"},   32'(done_cnt), 32'(exp_done));
        check({tag, "_err"},    32'(err_cnt), 32'(exp_err));
        check({tag, "_locked"}, 32'(locked), 32'(exp_lock));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"},      32'(wr_en), 32'd0);
        check({tag, "_wr_addr"},    32'(wr_addr), 32'd0);
        check({tag, "_wr_data"},    32'(wr_data), 32'd0);
        check({tag, "_locked"},     32'(locked), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_err"},        32'(err), 32'd0);
    endtask

    initial begin
        logic found;
        rst = 1'b1;
        vga_hs = 1'b1;
        vga_vs = 1'b1;
        {vga_r, vga_g, vga_b} = '0;
        cap_en = 1'b1;
        clear_stats();
        repeat (3) @(negedge vga_clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Frame 1 arms, frame 2 is captured
        clear_stats();
        drive_frame(-1);
        frame_checks("f1_arm", 0, 0, 0, 1'b0);

        clear_stats();
        fork
            drive_frame(-1);
            begin
                repeat (4) @(negedge vga_clk);
                check("f2_locked_at_start", 32'(locked), 32'd1);
            end
        join
        frame_checks("f2_cap", FB, 1, 0, 1'b1);
        check("f2_latency", 32'(first_wr_cyc - pix_cyc), 32'd2);
        check("f2_final_addr", 32'(exp_addr), 32'(FB));

        // Capture disabled for one frame, then re-enabled
        cap_en = 1'b0;
        clear_stats();
        drive_frame(-1);
        frame_checks("f3_nocap", 0, 0, 0, 1'b1);
        cap_en = 1'b1;
        clear_stats();
        drive_frame(-1);
        frame_checks("f4_cap", FB, 1, 0, 1'b1);

        // Short line 6 while locked: lines 4,5 and line 6 written, then err
        clear_stats();
        drive_frame(6);
        frame_checks("f5_short", 48, 0, 1, 1'b0);
        check("f5_wr_after_err", 32'(post_err_wr), 32'd0);

        clear_stats();
        drive_frame(-1);
        frame_checks("f6_rearm", 0, 0, 0, 1'b0);
        clear_stats();
        drive_frame(-1);
        frame_checks("f7_relock", FB, 1, 0, 1'b1);

        // hsync lost for longer than the counter range
        clear_stats();
        repeat (1100) begin
            @(negedge vga_clk);
            vga_hs = 1'b1;
            vga_vs = 1'b1;
            {vga_r, vga_g, vga_b} = 24'hC0FFEE;
        end
        frame_checks("hs_lost", 0, 0, 1, 1'b0);

        clear_stats();
        drive_frame(-1);
        frame_checks("f8_arm", 0, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a captured frame
        clear_stats();
        fork
            drive_frame(-1);
            begin
                found = 1'b0;
                for (int k = 0; k < 600 && !found; k++) begin
                    @(posedge vga_clk);
                    #1;
                    if (wr_en && wr_addr == 19'd40) found = 1'b1;
                end
                check("f9_rst_trigger", 32'(found), 32'd1);
                if (found) begin
                    #1;
                    rst = 1'b1;
                    #1;
                    check_outputs_zero("async_rst");
                    @(negedge vga_clk);
                    @(negedge vga_clk);
                    rst = 1'b0;
                    clear_stats();
                end
            end
        join
        frame_checks("f9_after_rst", 0, 0, 0, 1'b0);

        clear_stats();
        drive_frame(-1);
        frame_checks("f10_arm", 0, 0, 0, 1'b0);
        clear_stats();
        drive_frame(-1);
        frame_checks("f11_cap", FB, 1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_SYNC, default 96: hsync low width in clocks.
REQ-002 SHALL have parameter H_BACK, default 48: clocks from hsync end to first active pixel.
REQ-003 SHALL have parameter H_ACTIVE, default 640; H_TOTAL, default 800.
REQ-004 SHALL have parameter V_SYNC, default 2; V_BACK, default 33; V_ACTIVE, default 480; V_TOTAL, default 525 (all in lines).
REQ-005 SHALL have ports:
  vga_clk  in  1   pixel clock, rising edge.
  rst      in  1   asynchronous, active-high reset.
  vga_hs   in  1   horizontal sync, active low.
  vga_vs   in  1   vertical sync, active low.
  vga_r / vga_g / vga_b  in  8 each   pixel colour.
  cap_en   in  1   capture enable, sampled at frame start.
  wr_en    out 1   frame-buffer write strobe.
  wr_addr  out 19  pixel address, row-major: y*H_ACTIVE+x.
  wr_data  out 24  {r,g,b}.
  locked   out 1   high while in LOCKED.
  frame_done out 1  one-cycle pulse after last pixel of a captured frame.
  err      out 1   one-cycle pulse on timing violation.

Function
REQ-006 SHALL register vga_hs, vga_vs, and RGB once (stage S1); hs/vs edges detected on S1 versus previous S1 value.
REQ-007 SHALL reset x_cnt to 0 on the cycle an hs falling edge is detected, else increment; saturate at 1023.
REQ-008 SHALL set y_cnt to 0 on the first hs falling edge at or after a vs falling edge; else increment y_cnt on each hs falling edge; saturate at 1023.
REQ-009 SHALL define active pixel as H_SYNC+H_BACK <= x_cnt < H_SYNC+H_BACK+H_ACTIVE (144..783) AND V_SYNC+V_BACK <= y_cnt < V_SYNC+V_BACK+V_ACTIVE (35..514).
REQ-010 SHALL implement states SEARCH, ARM, LOCKED.
REQ-011 SEARCH -> ARM at y_cnt reset (REQ-008); clear line/frame check flags.
REQ-012 ARM -> LOCKED at next y_cnt reset if every line in the frame measured exactly H_TOTAL clocks and the frame held exactly V_TOTAL lines.
REQ-013 Any state -> SEARCH with err pulse when: hs falling edge with x_cnt != H_TOTAL-1 (except the first edge after SEARCH); y_cnt reset with y_cnt != V_TOTAL-1 (in ARM/LOCKED); x_cnt reaches 1023 (hsync lost).
REQ-014 SHALL latch cap_en into frame_cap at each y_cnt reset; writes occur only when state==LOCKED and frame_cap==1.
REQ-015 SHALL assert wr_en for exactly one cycle per active pixel; wr_data is that pixel's S1 value; latency vga_* pins -> wr_data/wr_en = 2 cycles.
REQ-016 wr_addr SHALL be a counter cleared at y_cnt reset and incremented after each write; range 0..307199; no wrap within a frame.
REQ-017 frame_done SHALL pulse the cycle after the write with wr_addr=307199.
REQ-018 Error mid-frame SHALL stop writes immediately (same cycle err asserts); no frame_done for that frame.
REQ-019 Simultaneous vs and hs falling edges SHALL be treated as y_cnt reset on that edge.
REQ-020 No backpressure: sink SHALL accept a write every cycle.

Reset
REQ-021 On rst: state=SEARCH, x_cnt=y_cnt=0, wr_addr=0, frame_cap=0; wr_en, locked, frame_done, err = 0; wr_data=0; S1 hs/vs registers = 1.
REQ-022 Reset mid-frame SHALL abort capture; relock requires a full clean ARM frame.

Structure
REQ-023 Timing defaults, state encoding, and derived constants (HDE_START=144, HDE_END=784, VDE_START=35, VDE_END=515, FB_WORDS=307200) SHALL live in shared package vga_timing_pkg.
REQ-024 SHALL use one sub-module vga_sync_edge (S1 register plus falling-edge pulse) instantiated for hs and vs.

Verification
REQ-025 Reset then two clean 640x480@800x525 frames, cap_en=1 -> locked high at start of frame 2; 307200 writes in frame 2, addresses 0..307199, frame_done once.
REQ-026 Pixel pattern data=(x,y,x^y) -> wr_data at wr_addr=y*640+x matches exactly; first write 2 cycles after pixel at x_cnt=144, y_cnt=35.
REQ-027 While locked, one line of 799 clocks -> err pulse at that hs edge, locked=0, no further writes, no frame_done; relock after one clean frame.
REQ-028 cap_en=0 at a frame start -> locked stays 1, zero writes that frame; cap_en=1 next frame -> full capture.
REQ-029 Hold vga_hs high >1023 clocks while locked -> err pulse, SEARCH.
REQ-030 Assert rst at wr_addr=1000 -> all outputs 0 within one cycle asynchronously; locked only after a further ARM frame.
